pe_seq_feeder: RTL and testbench

- Transmit-side front end for the 16-lane nucleotide substitution engine.
- Accepts a parent sequence as a stream of ASCII nucleotide characters and packs 16 nucleotides into each 32-bit nucl_alig word.
- Builds and holds the 160-bit matrix_P from a narrow 10-bit write port.
- Issues words to the engine and tags each returned 32-bit result with its valid-nucleotide count and a last flag. The tags are aligned by a latency-matched shift pipeline.

---
 rtl/pe_seq_feeder_pkg.sv | 49 ++++
 rtl/pe_seq_feeder_tag_delay.sv | 43 ++++
 rtl/pe_seq_feeder.sv | 134 +++++++++++++
 tb/tb_pe_seq_feeder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_seq_feeder_pkg.sv
// Shared definitions for the nucleotide feeder: nucleotide codes, word and
// matrix geometry, FSM state type, result tag type and the ASCII decoder.
package pe_seq_feeder_pkg;

    localparam logic [1:0] NUC_A = 2'b00;
    localparam logic [1:0] NUC_C = 2'b01;
    localparam logic [1:0] NUC_G = 2'b10;
    localparam logic [1:0] NUC_T = 2'b11;

    localparam int unsigned NUC_PER_WORD = 16;
    localparam int unsigned PROB_W       = 10;
    localparam int unsigned ROW_W        = 40;
    localparam int unsigned MAT_W        = 160;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StIssue,
        StDrain
    } feeder_state_t;

    // Tag travelling alongside a word through the engine latency.
    typedef struct packed {
        logic       valid;
        logic [4:0] count;
        logic       last;
    } pe_tag_t;

    typedef struct packed {
        logic       ok;
        logic [1:0] code;
    } nuc_dec_t;

    // Case-insensitive ACGT decode; anything else yields code A with ok=0.
    function automatic nuc_dec_t nuc_decode(input logic [7:0] ch);
        nuc_dec_t d;
        d.ok   = 1'b1;
        d.code = NUC_A;
        case (ch)
            8'h41, 8'h61: d.code = NUC_A;
            8'h43, 8'h63: d.code = NUC_C;
            8'h47, 8'h67: d.code = NUC_G;
            8'h54, 8'h74: d.code = NUC_T;
            default:      d.ok   = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pe_seq_feeder_tag_delay.sv
// pe_tag_delay: PE_LATENCY-deep shift pipeline carrying {valid, count, last}
// so result tags line up with the engine output.
//   clk, reset : clock, async active-high reset (clears all stages)
//   tag_in     : tag entering on the issue cycle
//   tag_out    : final stage, aligned with the engine result
//   busy       : any stage holds a valid tag
module pe_tag_delay
    import pe_seq_feeder_pkg::*;
#(
    parameter int unsigned PE_LATENCY = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  pe_tag_t tag_in,
    output pe_tag_t tag_out,
    output logic    busy
);

    pe_tag_t stage [PE_LATENCY];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(PE_LATENCY); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < int'(PE_LATENCY); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[PE_LATENCY-1];

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < int'(PE_LATENCY); i++) begin
            busy = busy | stage[i].valid;
        end
    end

endmodule

// File: rtl/pe_seq_feeder.sv
// pe_seq_feeder: packs ASCII nucleotides 16 per 32-bit word for the
// substitution engine, holds the 160-bit transition matrix, and tags each
// engine result with its nucleotide count and last flag.
//   clk, reset            : clock, async active-high reset
//   in_valid/ready/char/last : character stream input
//   mat_we/addr/data/ready : matrix entry write port (IDLE, nothing in flight)
//   nucl_alig, matrix_P   : engine operands
//   issue_valid           : nucl_alig updated this cycle
//   res_valid/count/last  : tag aligned with the engine result
//   err_char              : sticky non-ACGT flag
module pe_seq_feeder
    import pe_seq_feeder_pkg::*;
#(
    parameter int unsigned PE_LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_char,
    input  logic               in_last,
    input  logic               mat_we,
    input  logic [3:0]         mat_addr,
    input  logic [PROB_W-1:0]  mat_data,
    output logic               mat_ready,
    output logic [31:0]        nucl_alig,
    output logic [MAT_W-1:0]   matrix_P,
    output logic               issue_valid,
    output logic               res_valid,
    output logic [4:0]         res_count,
    output logic               res_last,
    output logic               err_char
);

    feeder_state_t state;
    logic [3:0]    pos;
    logic [31:0]   word_buf;
    logic [4:0]    tag_count;
    logic          tag_last;
    logic          tags_busy;
    logic          accept;
    nuc_dec_t      dec;
    logic [31:0]   merged_word;
    pe_tag_t       tag_in;
    pe_tag_t       tag_out;

    assign in_ready  = (state == StIdle) || (state == StFill);
    assign mat_ready = (state == StIdle) && !tags_busy;
    assign accept    = in_valid && in_ready;

    // Unfilled positions of word_buf are always zero, giving 00 padding.
    always_comb begin
        dec         = nuc_decode(in_char);
        merged_word = word_buf | (32'(dec.code) << {pos, 1'b0});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            pos         <= '0;
            word_buf    <= '0;
            nucl_alig   <= '0;
            issue_valid <= 1'b0;
            tag_count   <= '0;
            tag_last    <= 1'b0;
            err_char    <= 1'b0;
            matrix_P    <= '0;
        end else begin
            issue_valid <= 1'b0;
            if (accept && !dec.ok) begin
                err_char <= 1'b1;
            end
            unique case (state)
                StIdle, StFill: begin
                    if (accept) begin
                        if (pos == 4'(NUC_PER_WORD - 1) || in_last) begin
                            nucl_alig   <= merged_word;
                            issue_valid <= 1'b1;
                            tag_count   <= {1'b0, pos} + 5'd1;
                            tag_last    <= in_last;
                            word_buf    <= '0;
                            pos         <= '0;
                            state       <= StIssue;
                        end else begin
                            word_buf <= merged_word;
                            pos      <= pos + 4'd1;
                            state    <= StFill;
                        end
                    end
                end
                StIssue: state <= tag_last ? StDrain : StIdle;
                StDrain: begin
                    if (tag_out.valid && tag_out.last) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
            if (mat_we && mat_ready) begin
                for (int k = 0; k < 16; k++) begin
                    if (mat_addr == 4'(k)) begin
                        matrix_P[MAT_W - 1 - ROW_W * (k / 4) - PROB_W * (k % 4) -: PROB_W]
                            <= mat_data;
                    end
                end
            end
        end
    end

    // Only the issue cycle injects a valid tag; idle slots carry zeros.
    always_comb begin
        tag_in = '0;
        if (issue_valid) begin
            tag_in.valid = 1'b1;
            tag_in.count = tag_count;
            tag_in.last  = tag_last;
        end
    end

    pe_tag_delay #(
        .PE_LATENCY(PE_LATENCY)
    ) u_tag_delay (
        .clk    (clk),
        .reset  (reset),
        .tag_in (tag_in),
        .tag_out(tag_out),
        .busy   (tags_busy)
    );

    assign res_valid = tag_out.valid;
    assign res_count = tag_out.count;
    assign res_last  = tag_out.last;

endmodule

// File: tb/tb_pe_seq_feeder.sv
// Directed bench for pe_seq_feeder with PE_LATENCY=2. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_pe_seq_feeder;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_char;
    logic         in_last;
    logic         mat_we;
    logic [3:0]   mat_addr;
    logic [9:0]   mat_data;
    logic         mat_ready;
    logic [31:0]  nucl_alig;
    logic [159:0] matrix_P;
    logic         issue_valid;
    logic         res_valid;
    logic [4:0]   res_count;
    logic         res_last;
    logic         err_char;

    int n_checks = 0;
    int n_fail   = 0;

    pe_seq_feeder #(
        .PE_LATENCY(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .in_last    (in_last),
        .mat_we     (mat_we),
        .mat_addr   (mat_addr),
        .mat_data   (mat_data),
        .mat_ready  (mat_ready),
        .nucl_alig  (nucl_alig),
        .matrix_P   (matrix_P),
        .issue_valid(issue_valid),
        .res_valid  (res_valid),
        .res_count  (res_count),
        .res_last   (res_last),
        .err_char   (err_char)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Waits (bounded) for in_ready, then presents one character for one cycle.
    task automatic send(input logic [7:0] c, input logic last);
        int n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("send_ready_wait", in_ready, 1'b1);
        in_valid = 1'b1;
        in_char  = c;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_in_ready"}, in_ready, 1'b1);
        chk({pfx, "_mat_ready"}, mat_ready, 1'b1);
        chk({pfx, "_nucl_alig"}, nucl_alig, 32'h0);
        chk({pfx, "_matrix_P"}, matrix_P, 160'h0);
        chk({pfx, "_issue_valid"}, issue_valid, 1'b0);
        chk({pfx, "_res_valid"}, res_valid, 1'b0);
        chk({pfx, "_res_count"}, res_count, 5'd0);
        chk({pfx, "_res_last"}, res_last, 1'b0);
        chk({pfx, "_err_char"}, err_char, 1'b0);
    endtask

    initial begin
        string s;
        int    acc;
        int    lows[$];
        int    pulses[$];

        reset    = 1'b1;
        in_valid = 1'b0;
        in_char  = 8'h0;
        in_last  = 1'b0;
        mat_we   = 1'b0;
        mat_addr = 4'h0;
        mat_data = 10'h0;
        tick();
        tick();
        check_reset_values("rst");
        reset = 1'b0;
        tick();

        // Matrix load: entry k gets k+1.
        for (int k = 0; k < 16; k++) begin
            mat_we   = 1'b1;
            mat_addr = 4'(k);
            mat_data = 10'(k + 1);
            tick();
        end
        mat_we = 1'b0;
        chk("mat_e0", matrix_P[159:150], 10'd1);
        chk("mat_e15", matrix_P[9:0], 10'd16);
        chk("mat_e4", matrix_P[119:110], 10'd5);
        chk("mat_e11", matrix_P[49:40], 10'd12);

        // Full word, with an ignored matrix write during FILL.
        s = "ACGTACGTACGTACGT";
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                chk("mat_ready_fill", mat_ready, 1'b0);
                mat_we   = 1'b1;
                mat_addr = 4'd0;
                mat_data = 10'h3FF;
            end
            send(s[i], i == 15);
            mat_we = 1'b0;
        end
        chk("full_issue_valid", issue_valid, 1'b1);
        chk("full_nucl_alig", nucl_alig, 32'hE4E4E4E4);
        chk("full_in_ready_issue", in_ready, 1'b0);
        chk("mat_ignored_fill", matrix_P[159:150], 10'd1);
        tick();
        chk("full_issue_pulse_end", issue_valid, 1'b0);
        chk("full_res_not_yet", res_valid, 1'b0);
        chk("full_drain_in_ready", in_ready, 1'b0);
        tick();
        chk("full_res_valid", res_valid, 1'b1);
        chk("full_res_count", res_count, 5'd16);
        chk("full_res_last", res_last, 1'b1);
        tick();
        chk("full_res_done", res_valid, 1'b0);
        chk("full_idle_in_ready", in_ready, 1'b1);
        chk("full_idle_mat_ready", mat_ready, 1'b1);
        chk("full_nucl_hold", nucl_alig, 32'hE4E4E4E4);

        // Short tail: 19 x 'T'.
        for (int i = 0; i < 16; i++) send("T", 1'b0);
        chk("tail_w0_issue", issue_valid, 1'b1);
        chk("tail_w0_word", nucl_alig, 32'hFFFFFFFF);
        send("t", 1'b0);
        chk("tail_w0_res_valid", res_valid, 1'b1);
        chk("tail_w0_res_count", res_count, 5'd16);
        chk("tail_w0_res_last", res_last, 1'b0);
        send("T", 1'b0);
        send("T", 1'b1);
        chk("tail_w1_issue", issue_valid, 1'b1);
        chk("tail_w1_word", nucl_alig, 32'h0000003F);
        tick();
        tick();
        chk("tail_w1_res_valid", res_valid, 1'b1);
        chk("tail_w1_res_count", res_count, 5'd3);
        chk("tail_w1_res_last", res_last, 1'b1);
        tick();

        // Invalid character.
        chk("err_before", err_char, 1'b0);
        send("A", 1'b0);
        send("X", 1'b0);
        chk("err_set", err_char, 1'b1);
        send("a", 1'b1);
        chk("inv_issue", issue_valid, 1'b1);
        chk("inv_word", nucl_alig, 32'h00000000);
        tick();
        tick();
        chk("inv_res_valid", res_valid, 1'b1);
        chk("inv_res_count", res_count, 5'd3);
        chk("inv_res_last", res_last, 1'b1);
        tick();
        chk("err_sticky", err_char, 1'b1);

        // Back-to-back: in_valid held high for 32 'G' accepts.
        acc = 0;
        in_char = "G";
        for (int cyc = 0; cyc < 34; cyc++) begin
            if (issue_valid) pulses.push_back(cyc);
            if (!in_ready) lows.push_back(cyc);
            if (acc < 32) begin
                in_valid = 1'b1;
                in_last  = (acc == 31);
                if (in_ready) acc++;
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("b2b_accepts", 32'(acc), 32'd32);
        chk("b2b_low_count", 32'(lows.size()), 32'd2);
        chk("b2b_pulse_count", 32'(pulses.size()), 32'd2);
        if (lows.size() == 2) begin
            chk("b2b_low0", 32'(lows[0]), 32'd16);
            chk("b2b_low1", 32'(lows[1]), 32'd33);
        end
        if (pulses.size() == 2) begin
            chk("b2b_pulse_gap", 32'(pulses[1] - pulses[0]), 32'd17);
        end
        chk("b2b_word", nucl_alig, 32'hAAAAAAAA);
        tick();
        chk("b2b_res_valid", res_valid, 1'b1);
        chk("b2b_res_count", res_count, 5'd16);
        chk("b2b_res_last", res_last, 1'b1);
        tick();

        // Reset with a tag in flight.
        send("C", 1'b0);
        send("C", 1'b0);
        send("C", 1'b1);
        chk("mid_issue", issue_valid, 1'b1);
        tick();
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_no_res", res_valid, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
